l1_l2_arbiter: RTL
==================

// Module: l1_l2_arbiter
// PURPOSE
//  Arbitrates line-sized miss/writeback traffic from the L1 I-cache and L1 D-cache onto the single L2 port.
//  Sits between both L1 cache controllers (upstream) and the L2 cache (downstream).
//  Latches the winning request and holds it stable toward L2 until L2 responds.
//  Routes the response and read line back to the winner only.
// PARAMETERS
//  ADDR_W   16   byte address width (lc3b_word)
//  LINE_W  128   line width (lc3b_line)
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  i_mem_read     in   1       I-cache line read request; held until i_mem_resp
//  i_mem_address  in   ADDR_W  I-cache line address
//  i_mem_rdata    out  LINE_W  line returned to I-cache
//  i_mem_resp     out  1       one-cycle completion pulse to I-cache
//  d_mem_read     in   1       D-cache line read request; held until d_mem_resp
//  d_mem_write    in   1       D-cache writeback request; held until d_mem_resp
//  d_mem_address  in   ADDR_W  D-cache line address
//  d_mem_wdata    in   LINE_W  D-cache writeback line
//  d_mem_rdata    out  LINE_W  line returned to D-cache
//  d_mem_resp     out  1       one-cycle completion pulse to D-cache
//  l2_read        out  1       read request to L2
//  l2_write       out  1       write request to L2
//  l2_address     out  ADDR_W  latched address to L2
//  l2_wdata       out  LINE_W  latched write line to L2
//  l2_rdata       in   LINE_W  line from L2, valid with l2_resp
//  l2_resp        in   1       one-cycle L2 completion pulse
// BEHAVIOUR
//  Reset (synchronous, active-high): state=IDLE, last_grant=I.
//    All outputs 0: l2_read, l2_write, l2_address, l2_wdata, i/d_mem_resp, i/d_mem_rdata.
//  States: IDLE, GRANT_I, GRANT_D, DONE.
//  IDLE: at most one grant per cycle.
//    Only I requests -> GRANT_I. Only D (read or write) -> GRANT_D.
//    Both request -> grant the side NOT equal to last_grant (round-robin).
//    On grant: latch address (and d_mem_wdata, read/write kind) into the request register; update last_grant.
//  GRANT_x: l2_read/l2_write driven from the latched kind, l2_address/l2_wdata from the latch.
//    Latency: request seen in IDLE at cycle N -> l2_read/l2_write high from cycle N+1.
//    L1 inputs are ignored while in GRANT_x; the latched values stay stable.
//    l2_resp=1 -> x_mem_resp=1 combinationally in the same cycle; x_mem_rdata=l2_rdata; next state DONE.
//    The other L1's resp stays 0; its rdata is held at 0.
//  DONE: one bubble cycle. No grant, l2_read/l2_write=0. Lets the served L1 drop its request. -> IDLE.
//  D request with read and write both high is illegal; treat it as a write. The bench flags it.
//  Back-to-back requests from one side: minimum of 3 cycles between that side's resps (grant, L2 >=1, DONE).
//  No starvation: with both sides requesting continuously, grants strictly alternate.
//  Reset mid-transaction: abandon it; next cycle is IDLE with all outputs 0. L2 is reset by the same reset.
//  l2_resp in IDLE/DONE is a protocol error: ignored, no L1 resp generated.
// STRUCTURE
//  lc3b_types gains: typedef enum {arb_idle, arb_grant_i, arb_grant_d, arb_done} lc3b_arb_state.
//  Reuse lc3b_word/lc3b_line for address and data.
//  Single module, no sub-module.
//  Internal pieces: state reg; last_grant reg; request latch (address, wdata, is_write); output mux.
// TESTING
//  1 I read 0x1230 alone; L2 resp after 4 cycles -> l2_read high cycle 1, l2_address=0x1230,
//    i_mem_resp pulse with rdata; d_mem_resp stays 0.
//  2 D write 0x8040, wdata=128'hA5..A5 -> l2_write=1, l2_wdata matches; i_mem_* untouched.
//    Change d_mem_wdata mid-grant -> l2_wdata unchanged.
//  3 I and D requests asserted in the same cycle after reset (last_grant=I) -> D served first, then I.
//    I request held for the whole D transaction plus DONE.
//  4 Both request continuously for 6 transactions -> grant order D,I,D,I,D,I.
//    DONE cycle between each; no l2_read/l2_write overlap.
//  5 Reset asserted during GRANT_D with L2 pending -> next cycle l2_write=0, state IDLE.
//    A late l2_resp produces no d_mem_resp.
//  6 Spurious l2_resp in IDLE -> no i/d_mem_resp.
//    D request with read=write=1 -> served as write (l2_write=1, l2_read=0).

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and L1/L2 arbiter state encodings
package lc3b_types;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    arb_idle,
    arb_grant_i,
    arb_grant_d,
    arb_done
  } lc3b_arb_state;

  typedef enum logic {
    arb_side_i,
    arb_side_d
  } lc3b_arb_side;

  // Round-robin pick when both L1s request: favour whoever did not win last.
  function automatic lc3b_arb_side arb_pick(input logic i_req, input logic d_req,
                                            input lc3b_arb_side last);
    if (i_req && d_req) return (last == arb_side_i) ? arb_side_d : arb_side_i;
    else if (d_req)     return arb_side_d;
    else                return arb_side_i;
  endfunction

endpackage

// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - round-robin arbiter of I/D-cache line traffic onto one L2 port
module l1_l2_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,

  input  logic     i_mem_read,
  input  lc3b_word i_mem_address,
  output lc3b_line i_mem_rdata,
  output logic     i_mem_resp,

  input  logic     d_mem_read,
  input  logic     d_mem_write,
  input  lc3b_word d_mem_address,
  input  lc3b_line d_mem_wdata,
  output lc3b_line d_mem_rdata,
  output logic     d_mem_resp,

  output logic     l2_read,
  output logic     l2_write,
  output lc3b_word l2_address,
  output lc3b_line l2_wdata,
  input  lc3b_line l2_rdata,
  input  logic     l2_resp
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_next_state;
  lc3b_arb_side  r_last_grant;
  lc3b_arb_side  w_pick;

  lc3b_word r_req_address;
  lc3b_line r_req_wdata;
  logic     r_req_is_write;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;

  assign w_i_req = i_mem_read;
  assign w_d_req = d_mem_read | d_mem_write;
  assign w_pick  = arb_pick(w_i_req, w_d_req, r_last_grant);

  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      arb_idle: begin
        if (w_i_req || w_d_req) begin
          if (w_pick == arb_side_d) begin
            w_grant_d    = 1'b1;
            w_next_state = arb_grant_d;
          end else begin
            w_grant_i    = 1'b1;
            w_next_state = arb_grant_i;
          end
        end
      end
      arb_grant_i, arb_grant_d: begin
        if (l2_resp) w_next_state = arb_done;
      end
      arb_done: w_next_state = arb_idle;
      default:  w_next_state = arb_idle;
    endcase
  end

  // A D request with both read and write high is resolved as a writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= arb_idle;
      r_last_grant   <= arb_side_i;
      r_req_address  <= '0;
      r_req_wdata    <= '0;
      r_req_is_write <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_i) begin
        r_last_grant   <= arb_side_i;
        r_req_address  <= i_mem_address;
        r_req_wdata    <= '0;
        r_req_is_write <= 1'b0;
      end else if (w_grant_d) begin
        r_last_grant   <= arb_side_d;
        r_req_address  <= d_mem_address;
        r_req_wdata    <= d_mem_wdata;
        r_req_is_write <= d_mem_write;
      end
    end
  end

  assign w_busy = (r_state == arb_grant_i) || (r_state == arb_grant_d);

  always_comb begin
    l2_read     = w_busy && !r_req_is_write;
    l2_write    = w_busy && r_req_is_write;
    l2_address  = r_req_address;
    l2_wdata    = r_req_wdata;
    i_mem_resp  = (r_state == arb_grant_i) && l2_resp;
    d_mem_resp  = (r_state == arb_grant_d) && l2_resp;
    i_mem_rdata = i_mem_resp ? l2_rdata : '0;
    d_mem_rdata = d_mem_resp ? l2_rdata : '0;
  end

endmodule
